// File: rtl/sum_accum_stage_if.sv
// rtl/sum_accum_stage_if.sv - handshake bundle between the adder pipeline, sum_accum_stage and its consumer
//
// Signals:
//   in_valid / in_ready / in_sum : 17-bit adder result stream into the stage
//   flush                        : request to close the current partial block
//   out_valid / out_ready        : block result handshake
//   out_data                     : block total, ACC_W bits, modulo 2^ACC_W
//   out_count                    : number of sums in the block, CNT_W bits
//   out_ovf                      : set when some add within the block carried out of ACC_W
// Modports:
//   master : environment side (upstream producer plus downstream consumer)
//   slave  : the accumulator stage
interface sum_accum_stage_if #(
    parameter int ACC_W = 20,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [16:0]      in_sum;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid,
        output in_sum,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_sum,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count,
        output out_ovf
    );
endinterface

// File: rtl/sum_accum_stage.sv
// rtl/sum_accum_stage.sv - accumulates BLOCK_LEN adder sums per block and emits one block total
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous, active-high reset; discards any partial block and any pending output
//   bus : sum_accum_stage_if.slave
//         in_valid/in_ready/in_sum   - 17-bit unsigned sum stream {carry, sum[15:0]}
//         flush                      - close the current block early (ignored while in_ready=0)
//         out_valid/out_ready        - block result handshake
//         out_data/out_count/out_ovf - block total (mod 2^ACC_W), sums in block, sticky carry-out
//
// A block closes either on the BLOCK_LEN-th accepted sum or on an honoured flush
// with at least one sum in the block (the sum accepted in the same cycle counts).
// The output register is a single slot; because in_ready also rises when the
// consumer takes the slot, a new block can close in the very cycle the old one
// drains, which gives back-to-back results with no bubble.
module sum_accum_stage #(
    parameter int BLOCK_LEN = 4,
    parameter int ACC_W     = 20,
    parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    sum_accum_stage_if.slave bus
);
    localparam int SUM_W = 17;

    // running block state
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    // output slot
    logic             out_valid_r;
    logic [ACC_W-1:0] out_data_r;
    logic [CNT_W-1:0] out_count_r;
    logic             out_ovf_r;

    // combinational next-block values
    logic             in_ready;
    logic             accept;
    logic [ACC_W:0]   tmp;
    logic [ACC_W-1:0] new_acc;
    logic [CNT_W-1:0] new_cnt;
    logic             new_ovf;
    logic             full_close;
    logic             flush_close;
    logic             close;

    // The slot is free, or will be freed by the consumer at this edge.
    assign in_ready = !out_valid_r || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        // one extra bit so the carry out of ACC_W is visible
        tmp     = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, bus.in_sum};
        new_acc = acc;
        new_cnt = cnt;
        new_ovf = ovf;
        if (accept) begin
            new_acc = tmp[ACC_W-1:0];
            new_cnt = cnt + CNT_W'(1);
            new_ovf = ovf | tmp[ACC_W];
        end
    end

    // A flush on the BLOCK_LEN-th sum is covered by full_close alone, so only
    // one block is ever produced for it. new_cnt==0 means there is nothing to
    // close, which suppresses empty blocks.
    always_comb begin
        full_close  = accept && (cnt == CNT_W'(BLOCK_LEN - 1));
        flush_close = bus.flush && in_ready && (new_cnt != '0);
        close       = full_close || flush_close;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_count_r <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            if (close) begin
                // load the slot (possibly replacing a block draining this cycle)
                out_valid_r <= 1'b1;
                out_data_r  <= new_acc;
                out_count_r <= new_cnt;
                out_ovf_r   <= new_ovf;
                acc         <= '0;
                cnt         <= '0;
                ovf         <= 1'b0;
            end else begin
                if (accept) begin
                    acc <= new_acc;
                    cnt <= new_cnt;
                    ovf <= new_ovf;
                end
                if (out_valid_r && bus.out_ready) begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_count = out_count_r;
    assign bus.out_ovf   = out_ovf_r;
endmodule

// File: tb/tb_sum_accum_stage.sv
// tb/tb_sum_accum_stage.sv - self-checking bench for sum_accum_stage (ACC_W=20 and ACC_W=17 instances)
module tb_sum_accum_stage;
    localparam int BL = 4;
    localparam int CW = 3;
    localparam longint MOD_A = 64'd1 << 20;
    localparam longint MOD_B = 64'd1 << 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sum_accum_stage_if #(.ACC_W(20), .CNT_W(CW)) ifa ();
    sum_accum_stage_if #(.ACC_W(17), .CNT_W(CW)) ifb ();

    sum_accum_stage #(.BLOCK_LEN(BL), .ACC_W(20), .CNT_W(CW)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    sum_accum_stage #(.BLOCK_LEN(BL), .ACC_W(17), .CNT_W(CW)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model: list of sums in the open block, plus the pending result
    int     blk[$];
    bit     m_pend = 1'b0;
    longint m_total = 0;
    int     m_count = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [16:0] s, input bit f, input bit r);
        ifa.in_valid  = v;
        ifa.in_sum    = s;
        ifa.flush     = f;
        ifa.out_ready = r;
        ifb.in_valid  = v;
        ifb.in_sum    = s;
        ifb.flush     = f;
        ifb.out_ready = r;
    endtask

    task automatic check_out();
        chk("valid_a", {31'd0, ifa.out_valid}, {31'd0, m_pend});
        chk("valid_b", {31'd0, ifb.out_valid}, {31'd0, m_pend});
        if (m_pend) begin
            chk("data_a",  32'(ifa.out_data),  32'(m_total % MOD_A));
            chk("count_a", 32'(ifa.out_count), 32'(m_count));
            chk("ovf_a",   32'(ifa.out_ovf),   32'(m_total >= MOD_A));
            chk("data_b",  32'(ifb.out_data),  32'(m_total % MOD_B));
            chk("count_b", 32'(ifb.out_count), 32'(m_count));
            chk("ovf_b",   32'(ifb.out_ovf),   32'(m_total >= MOD_B));
        end
    endtask

    // Called at a falling edge: apply inputs, check in_ready, advance the
    // model across the next rising edge, then check outputs at the falling edge.
    task automatic tick(input bit v, input logic [16:0] s, input bit f, input bit r);
        bit     rdy;
        bit     acc;
        bit     close;
        longint t;
        drive(v, s, f, r);
        #1;
        rdy = !m_pend || r;
        chk("in_ready_a", {31'd0, ifa.in_ready}, {31'd0, rdy});
        chk("in_ready_b", {31'd0, ifb.in_ready}, {31'd0, rdy});
        acc = v && rdy;
        if (acc) blk.push_back(int'(s));
        close = (acc && blk.size() == BL) || (f && rdy && blk.size() > 0);
        if (close) begin
            t = 0;
            foreach (blk[i]) t += longint'(blk[i]);
            m_total = t;
            m_count = blk.size();
            blk.delete();
            m_pend = 1'b1;
        end else if (m_pend && r) begin
            m_pend = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic do_reset();
        drive(1'b0, 17'd0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        blk.delete();
        m_pend = 1'b0;
    endtask

    initial begin
        logic [16:0] s;
        drive(1'b0, 17'd0, 1'b0, 1'b1);
        @(negedge clk);
        do_reset();
        chk("rst_valid", {31'd0, ifa.out_valid}, 32'd0);
        chk("rst_data",  32'(ifa.out_data), 32'd0);
        chk("rst_count", 32'(ifa.out_count), 32'd0);
        chk("rst_ovf",   {31'd0, ifa.out_ovf}, 32'd0);
        chk("rst_ready", {31'd0, ifa.in_ready}, 32'd1);

        // 1: basic block
        tick(1'b1, 17'h1_6665, 1'b0, 1'b1);
        tick(1'b1, 17'h1_6665, 1'b0, 1'b1);
        tick(1'b1, 17'h0_0001, 1'b0, 1'b1);
        tick(1'b1, 17'h0_0002, 1'b0, 1'b1);
        chk("t1_data",  32'(ifa.out_data), 32'h2_CCCD);
        chk("t1_count", 32'(ifa.out_count), 32'd4);
        chk("t1_ovf",   {31'd0, ifa.out_ovf}, 32'd0);

        // 2: back-to-back full blocks
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 17'h1_FFFF, 1'b0, 1'b1);
            if (i == 3 || i == 7) chk("t2_data", 32'(ifa.out_data), 32'h7_FFFC);
        end
        tick(1'b0, 17'd0, 1'b0, 1'b1);

        // 3: backpressure
        tick(1'b1, 17'd1, 1'b0, 1'b1);
        tick(1'b1, 17'd1, 1'b0, 1'b1);
        tick(1'b1, 17'd1, 1'b0, 1'b1);
        tick(1'b1, 17'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 17'd7, 1'b0, 1'b0);
        chk("t3_hold", 32'(ifa.out_data), 32'd5);
        tick(1'b1, 17'd7, 1'b0, 1'b1);
        tick(1'b0, 17'd0, 1'b1, 1'b1);
        chk("t3_pend", 32'(ifa.out_data), 32'd7);

        // 4: flush
        tick(1'b1, 17'd10, 1'b0, 1'b1);
        tick(1'b1, 17'd20, 1'b0, 1'b1);
        tick(1'b0, 17'd0, 1'b1, 1'b1);
        chk("t4_data",  32'(ifa.out_data), 32'd30);
        chk("t4_count", 32'(ifa.out_count), 32'd2);
        tick(1'b0, 17'd0, 1'b1, 1'b1);
        chk("t4_empty", {31'd0, ifa.out_valid}, 32'd0);
        tick(1'b1, 17'd10, 1'b0, 1'b1);
        tick(1'b1, 17'd20, 1'b0, 1'b1);
        tick(1'b1, 17'd5, 1'b1, 1'b1);
        chk("t4_data3",  32'(ifa.out_data), 32'd35);
        chk("t4_count3", 32'(ifa.out_count), 32'd3);

        // 5: overflow on the 17-bit instance
        for (int i = 0; i < 4; i++) tick(1'b1, 17'h1_0000, 1'b0, 1'b1);
        chk("t5_data", 32'(ifb.out_data), 32'd0);
        chk("t5_ovf",  {31'd0, ifb.out_ovf}, 32'd1);
        for (int i = 0; i < 4; i++) tick(1'b1, 17'd1, 1'b0, 1'b1);
        chk("t5_data2", 32'(ifb.out_data), 32'd4);
        chk("t5_ovf2",  {31'd0, ifb.out_ovf}, 32'd0);

        // 6: reset with a pending block, and with a partial block
        for (int i = 0; i < 3; i++) tick(1'b1, 17'd9, 1'b0, 1'b1);
        tick(1'b1, 17'd9, 1'b0, 1'b0);
        tick(1'b1, 17'd3, 1'b0, 1'b0);
        do_reset();
        chk("t6_valid", {31'd0, ifa.out_valid}, 32'd0);
        tick(1'b1, 17'd9, 1'b0, 1'b1);
        tick(1'b1, 17'd9, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 17'd1, 1'b0, 1'b1);
        chk("t6_data", 32'(ifa.out_data), 32'd4);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) s = 17'($urandom_range(0, 15));
            else s = 17'($urandom);
            tick($urandom_range(0, 9) < 7, s, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
